// File: rtl/gmii_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// gmii_rx_frame_ctrl
//
// Receives a GMII byte stream, checks and strips the preamble/SFD, and
// forwards the frame bytes (DA through FCS) with start/end markers, a length
// and an error flag at end of frame. Good and bad frames are counted in
// saturating 16-bit counters.
//
// Ports
//   gmii_rx_clk  in   receive clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   pll_lock     in   1 = receive clock usable
//   rx_en        in   receive enable, only looked at while idle
//   gmii_rx_dv   in   GMII data valid
//   gmii_rxd     in   GMII byte
//   frm_valid    out  frm_data valid this cycle
//   frm_data     out  frame byte
//   frm_sof      out  first byte of frame (with frm_valid)
//   frm_eof      out  last byte of frame (with frm_valid)
//   frm_err      out  frame bad (with frm_eof)
//   frm_len      out  frame byte count (with frm_eof)
//   frm_ok_cnt   out  good frame count, saturating
//   frm_err_cnt  out  bad frame / preamble failure count, saturating
//
// Data path: each received byte is parked in a one-byte hold register and
// only released when the next byte arrives (or the frame ends). That one
// byte of look-ahead is what lets the last byte carry frm_eof, and it gives
// a fixed two-cycle latency with no bubbles.
// ---------------------------------------------------------------------------
module gmii_rx_frame_ctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        pll_lock,
    input  logic        rx_en,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        frm_valid,
    output logic [7:0]  frm_data,
    output logic        frm_sof,
    output logic        frm_eof,
    output logic        frm_err,
    output logic [10:0] frm_len,
    output logic [15:0] frm_ok_cnt,
    output logic [15:0] frm_err_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_e;

    state_e      state_q;
    logic [2:0]  pre_cnt_q;
    logic [10:0] byte_cnt_q;
    logic [7:0]  hold_q;

    logic short_frame;
    logic at_max;
    logic held_is_first;

    assign short_frame   = byte_cnt_q < 11'(MIN_LEN);
    assign at_max        = byte_cnt_q == 11'(MAX_LEN);
    // When the hold register contains byte 1 of the frame, whatever it emits
    // next is the start of frame.
    assign held_is_first = byte_cnt_q == 11'd1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pre_cnt_q   <= 3'd0;
            byte_cnt_q  <= 11'd0;
            hold_q      <= 8'd0;
            frm_valid   <= 1'b0;
            frm_data    <= 8'd0;
            frm_sof     <= 1'b0;
            frm_eof     <= 1'b0;
            frm_err     <= 1'b0;
            frm_len     <= 11'd0;
            frm_ok_cnt  <= 16'd0;
            frm_err_cnt <= 16'd0;
        end else begin
            // Markers are single-cycle pulses; only the branches that emit a
            // byte raise them.
            frm_valid <= 1'b0;
            frm_sof   <= 1'b0;
            frm_eof   <= 1'b0;
            frm_err   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (gmii_rx_dv) begin
                        if (gmii_rxd == 8'h55 && pll_lock && rx_en) begin
                            state_q   <= PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            // Joined mid-stream or not allowed to receive:
                            // skip the burst silently.
                            state_q <= DROP;
                        end
                    end
                end

                PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q     <= IDLE;
                        frm_err_cnt <= sat_inc(frm_err_cnt);
                    end else if (gmii_rxd == 8'h55) begin
                        if (pre_cnt_q != 3'd7) begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end else if (gmii_rxd == 8'hD5 && pre_cnt_q != 3'd0) begin
                        state_q    <= DATA;
                        byte_cnt_q <= 11'd0;
                    end else begin
                        state_q     <= DROP;
                        frm_err_cnt <= sat_inc(frm_err_cnt);
                    end
                end

                DATA: begin
                    if (!pll_lock || !gmii_rx_dv) begin
                        // End of frame, normal or forced by loss of lock.
                        // The byte on the bus (if any) is discarded.
                        state_q <= pll_lock ? IDLE : DROP;
                        if (byte_cnt_q == 11'd0) begin
                            // Nothing after the SFD: nothing to flush.
                            frm_err_cnt <= sat_inc(frm_err_cnt);
                        end else begin
                            frm_valid <= 1'b1;
                            frm_data  <= hold_q;
                            frm_sof   <= held_is_first;
                            frm_eof   <= 1'b1;
                            frm_len   <= byte_cnt_q;
                            if (!pll_lock || short_frame) begin
                                frm_err     <= 1'b1;
                                frm_err_cnt <= sat_inc(frm_err_cnt);
                            end else begin
                                frm_ok_cnt <= sat_inc(frm_ok_cnt);
                            end
                        end
                    end else if (at_max) begin
                        // Byte MAX_LEN+1 arrived: close the frame on the held
                        // byte as an error and discard the rest of the burst.
                        state_q     <= DROP;
                        frm_valid   <= 1'b1;
                        frm_data    <= hold_q;
                        frm_sof     <= held_is_first;
                        frm_eof     <= 1'b1;
                        frm_err     <= 1'b1;
                        frm_len     <= byte_cnt_q;
                        frm_err_cnt <= sat_inc(frm_err_cnt);
                    end else begin
                        hold_q     <= gmii_rxd;
                        byte_cnt_q <= byte_cnt_q + 11'd1;
                        if (byte_cnt_q != 11'd0) begin
                            frm_valid <= 1'b1;
                            frm_data  <= hold_q;
                            frm_sof   <= held_is_first;
                        end
                    end
                end

                DROP: begin
                    if (!gmii_rx_dv) begin
                        state_q <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for gmii_rx_frame_ctrl. Frames are described at frame level
// (preamble length, payload length, byte seed, lock-loss point, enable).
// For each frame the expected output stream is worked out from the frame
// description alone: which bytes come out, which carries sof/eof, the
// resulting length/error and counter values, and the output cycle of every
// byte (input cycle + 2). A per-cycle compare process checks the DUT against
// that expected stream; directed literal checks pin the key numbers.
// ---------------------------------------------------------------------------
module tb_gmii_rx_frame_ctrl;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        rst;
    logic        pll_lock;
    logic        rx_en;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        frm_valid;
    logic [7:0]  frm_data;
    logic        frm_sof;
    logic        frm_eof;
    logic        frm_err;
    logic [10:0] frm_len;
    logic [15:0] frm_ok_cnt;
    logic [15:0] frm_err_cnt;

    gmii_rx_frame_ctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .gmii_rx_clk (clk),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .rx_en       (rx_en),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rxd    (gmii_rxd),
        .frm_valid   (frm_valid),
        .frm_data    (frm_data),
        .frm_sof     (frm_sof),
        .frm_eof     (frm_eof),
        .frm_err     (frm_err),
        .frm_len     (frm_len),
        .frm_ok_cnt  (frm_ok_cnt),
        .frm_err_cnt (frm_err_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        sof;
        logic        eof;
        logic        err;
        logic [10:0] len;
        logic [15:0] ok;
        logic [15:0] er;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_ok  = 16'd0;
    logic [15:0] exp_err = 16'd0;
    logic        chk_en  = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    // monitor observations used by the directed checks
    int          valid_total = 0;
    int          one_byte_total = 0;
    int unsigned sof_cyc = 0;
    logic [7:0]  eof_data = 8'd0;
    logic [10:0] eof_len = 11'd0;
    logic        eof_err = 1'b0;
    int unsigned last_t0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---------------- compare process ----------------
    exp_t cmp_e;
    always @(negedge clk) begin
        if (chk_en) begin
            if (frm_valid) begin
                valid_total++;
                if (frm_sof) sof_cyc = cyc;
                if (frm_eof) begin
                    eof_data = frm_data;
                    eof_len  = frm_len;
                    eof_err  = frm_err;
                    if (frm_sof) one_byte_total++;
                end
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                cmp_e = exp_q.pop_front();
                check("valid", {31'd0, frm_valid}, 32'd1);
                check("data",  {24'd0, frm_data}, {24'd0, cmp_e.data});
                check("sof",   {31'd0, frm_sof},  {31'd0, cmp_e.sof});
                check("eof",   {31'd0, frm_eof},  {31'd0, cmp_e.eof});
                if (cmp_e.eof) begin
                    check("err",     {31'd0, frm_err},     {31'd0, cmp_e.err});
                    check("len",     {21'd0, frm_len},     {21'd0, cmp_e.len});
                    check("ok_cnt",  {16'd0, frm_ok_cnt},  {16'd0, cmp_e.ok});
                    check("err_cnt", {16'd0, frm_err_cnt}, {16'd0, cmp_e.er});
                end
            end else begin
                check("no_valid", {31'd0, frm_valid}, 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic dv, input logic [7:0] d, input logic pl,
                         output int unsigned t);
        @(negedge clk);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        pll_lock   = pl;
        t          = cyc;
    endtask

    task automatic idle(input int n);
        int unsigned t;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1, t);
    endtask

    // pll_at  : lock is lost while payload byte pll_at is on the bus (-1: never)
    // en_off  : rx_en drops while payload byte en_off is on the bus (-1: never)
    task automatic send_frame(input int npre, input int nbytes, input logic [7:0] seed,
                              input int pll_at, input logic en, input int en_off);
        int          len;
        logic        err;
        int unsigned t;
        exp_t        e;
        logic [7:0]  b;
        rx_en = en;
        if (pll_at >= 0 && pll_at < nbytes) begin
            len = pll_at;
            err = 1'b1;
        end else if (nbytes > MAX_LEN) begin
            len = MAX_LEN;
            err = 1'b1;
        end else begin
            len = nbytes;
            err = (len < MIN_LEN);
        end
        if (!en) len = 0;
        else if (len == 0 || err) exp_err = sat16(exp_err);
        else exp_ok = sat16(exp_ok);

        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, 1'b1, t);
        drive(1'b1, 8'hD5, 1'b1, t);
        for (int i = 0; i < nbytes; i++) begin
            if (i == en_off) rx_en = 1'b0;
            b = 8'(int'(seed) + i);
            drive(1'b1, b, !(pll_at >= 0 && i >= pll_at), t);
            if (i == 0) last_t0 = t;
            if (i < len) begin
                e.cyc  = t + 2;
                e.data = b;
                e.sof  = (i == 0);
                e.eof  = (i == len - 1);
                e.err  = err;
                e.len  = 11'(len);
                e.ok   = exp_ok;
                e.er   = exp_err;
                exp_q.push_back(e);
            end
        end
        idle(4);
        rx_en = 1'b1;
    endtask

    task automatic check_counters(input string name);
        check({name, "_ok_model"},  {16'd0, frm_ok_cnt},  {16'd0, exp_ok});
        check({name, "_err_model"}, {16'd0, frm_err_cnt}, {16'd0, exp_err});
    endtask

    // ---------------- stimulus ----------------
    int          v0;
    int unsigned t;
    exp_t        e;

    initial begin
        rst        = 1'b1;
        pll_lock   = 1'b1;
        rx_en      = 1'b1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid",   {31'd0, frm_valid},   32'd0);
        check("rst_sof",     {31'd0, frm_sof},     32'd0);
        check("rst_eof",     {31'd0, frm_eof},     32'd0);
        check("rst_err",     {31'd0, frm_err},     32'd0);
        check("rst_data",    {24'd0, frm_data},    32'd0);
        check("rst_len",     {21'd0, frm_len},     32'd0);
        check("rst_ok_cnt",  {16'd0, frm_ok_cnt},  32'd0);
        check("rst_err_cnt", {16'd0, frm_err_cnt}, 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // good 64-byte frame 0x00..0x3F
        v0 = valid_total;
        send_frame(7, 64, 8'h00, -1, 1'b1, -1);
        check("good_nvalid", 32'(valid_total - v0), 32'd64);
        check("good_latency", sof_cyc - last_t0, 32'd2);
        check("good_eof_data", {24'd0, eof_data}, 32'h3F);
        check("good_len", {21'd0, eof_len}, 32'd64);
        check("good_err", {31'd0, eof_err}, 32'd0);
        check("good_ok_cnt", {16'd0, frm_ok_cnt}, 32'd1);
        check_counters("good");

        // short frame
        send_frame(7, 10, 8'hA0, -1, 1'b1, -1);
        check("short_len", {21'd0, eof_len}, 32'd10);
        check("short_err", {31'd0, eof_err}, 32'd1);
        check("short_err_cnt", {16'd0, frm_err_cnt}, 32'd1);

        // bad preamble byte
        v0 = valid_total;
        drive(1'b1, 8'h55, 1'b1, t);
        drive(1'b1, 8'h55, 1'b1, t);
        drive(1'b1, 8'h12, 1'b1, t);
        drive(1'b1, 8'h34, 1'b1, t);
        drive(1'b1, 8'hD5, 1'b1, t);
        idle(3);
        exp_err = sat16(exp_err);
        check("badpre_nvalid", 32'(valid_total - v0), 32'd0);
        check("badpre_err_cnt", {16'd0, frm_err_cnt}, 32'd2);

        // overlength then a normal frame
        send_frame(7, 1600, 8'h20, -1, 1'b1, -1);
        check("over_len", {21'd0, eof_len}, 32'd1518);
        check("over_err", {31'd0, eof_err}, 32'd1);
        check("over_err_cnt", {16'd0, frm_err_cnt}, 32'd3);
        send_frame(7, 64, 8'h40, -1, 1'b1, -1);
        check("after_over_ok_cnt", {16'd0, frm_ok_cnt}, 32'd2);

        // lock lost after 100 bytes
        send_frame(7, 150, 8'h10, 100, 1'b1, -1);
        check("pll_len", {21'd0, eof_len}, 32'd100);
        check("pll_err", {31'd0, eof_err}, 32'd1);
        check("pll_err_cnt", {16'd0, frm_err_cnt}, 32'd4);

        // receive disabled at frame start
        v0 = valid_total;
        send_frame(7, 80, 8'h00, -1, 1'b0, -1);
        check("rxen_nvalid", 32'(valid_total - v0), 32'd0);
        check("rxen_ok_cnt", {16'd0, frm_ok_cnt}, 32'd2);
        check("rxen_err_cnt", {16'd0, frm_err_cnt}, 32'd4);

        // one-byte frame, minimal preamble
        v0 = one_byte_total;
        send_frame(1, 1, 8'h77, -1, 1'b1, -1);
        check("one_sof_eof", 32'(one_byte_total - v0), 32'd1);
        check("one_len", {21'd0, eof_len}, 32'd1);
        check("one_data", {24'd0, eof_data}, 32'h77);

        // zero bytes after SFD
        v0 = valid_total;
        send_frame(7, 0, 8'h00, -1, 1'b1, -1);
        check("zero_nvalid", 32'(valid_total - v0), 32'd0);
        check("zero_err_cnt", {16'd0, frm_err_cnt}, 32'd6);

        // rx_en dropping mid-frame does not matter
        send_frame(3, 70, 8'h33, -1, 1'b1, 20);
        check("enoff_len", {21'd0, eof_len}, 32'd70);
        check("enoff_err", {31'd0, eof_err}, 32'd0);
        check("enoff_ok_cnt", {16'd0, frm_ok_cnt}, 32'd3);

        // dv falls inside the preamble
        drive(1'b1, 8'h55, 1'b1, t);
        drive(1'b1, 8'h55, 1'b1, t);
        idle(3);
        exp_err = sat16(exp_err);
        check("prefall_err_cnt", {16'd0, frm_err_cnt}, 32'd7);

        // length boundaries
        send_frame(7, MIN_LEN - 1, 8'h01, -1, 1'b1, -1);
        check("min_m1_err", {31'd0, eof_err}, 32'd1);
        send_frame(7, MIN_LEN, 8'h02, -1, 1'b1, -1);
        check("min_err", {31'd0, eof_err}, 32'd0);
        send_frame(7, MAX_LEN, 8'h03, -1, 1'b1, -1);
        check("max_len", {21'd0, eof_len}, 32'd1518);
        check("max_err", {31'd0, eof_err}, 32'd0);
        check("max_ok_cnt", {16'd0, frm_ok_cnt}, 32'd5);
        check_counters("bounds");

        // reset while byte 30 (index 29) is on the bus
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b1, t);
        drive(1'b1, 8'hD5, 1'b1, t);
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 8'(i), 1'b1, t);
            if (i == 29) rst = 1'b1;
            if (i == 30) begin
                rst = 1'b0;
                check("mrst_valid",   {31'd0, frm_valid},   32'd0);
                check("mrst_sof",     {31'd0, frm_sof},     32'd0);
                check("mrst_eof",     {31'd0, frm_eof},     32'd0);
                check("mrst_err",     {31'd0, frm_err},     32'd0);
                check("mrst_data",    {24'd0, frm_data},    32'd0);
                check("mrst_len",     {21'd0, frm_len},     32'd0);
                check("mrst_ok_cnt",  {16'd0, frm_ok_cnt},  32'd0);
                check("mrst_err_cnt", {16'd0, frm_err_cnt}, 32'd0);
                exp_ok  = 16'd0;
                exp_err = 16'd0;
            end
            if (i < 28) begin
                e.cyc  = t + 2;
                e.data = 8'(i);
                e.sof  = (i == 0);
                e.eof  = 1'b0;
                e.err  = 1'b0;
                e.len  = 11'd0;
                e.ok   = 16'd0;
                e.er   = 16'd0;
                exp_q.push_back(e);
            end
        end
        idle(4);
        send_frame(7, 64, 8'h80, -1, 1'b1, -1);
        check("post_rst_err", {31'd0, eof_err}, 32'd0);
        check("post_rst_ok_cnt", {16'd0, frm_ok_cnt}, 32'd1);
        check_counters("post_rst");

        idle(4);
        check("pending_exp", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
